// File: rtl/snoop_wb_pkg.sv
// Shared types and width helpers for the snoop/writeback controller.
// Widths are clamped to at least one bit so single-beat builds stay legal.
package snoop_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        FETCH = 2'd2
    } state_e;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int beat_w(input int b);
        return (b > 1) ? $clog2(b) : 1;
    endfunction

endpackage

// File: rtl/snoop_wb_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping.
// Zero latency, no backpressure; the pointer register lives in the parent.
module snoop_wb_rr_arb
    import snoop_wb_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]       req_i,
    input  logic [ch_w(N_CH)-1:0] ptr_i,
    output logic [N_CH-1:0]       grant_o,
    output logic [ch_w(N_CH)-1:0] idx_o,
    output logic                  any_o
);

    localparam int CH_W = ch_w(N_CH);
    localparam int PW   = CH_W + 1;

    logic [PW-1:0] pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = '0;
        for (int k = 0; k < N_CH; k++) begin
            // pos = (ptr + k) mod N_CH without a divider
            pos = {1'b0, ptr_i} + PW'(k);
            if (pos >= PW'(N_CH)) begin
                pos = pos - PW'(N_CH);
            end
            if (!any_o && req_i[pos[CH_W-1:0]]) begin
                any_o = 1'b1;
                idx_o = pos[CH_W-1:0];
            end
        end
        if (any_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/snoop_wb_ctrl.sv
// Snoop writeback controller: per-channel sticky pend bits, RR multi-beat bursts, fetches behind. Optional SVA via SNOOP_WB_ASSERT_EN.
// Hit-to-writeback 2 cycles, rd/wr-to-fetch 2 cycles; beats advance on wb_ack, fetch holds until fetch_ack.
module snoop_wb_ctrl
    import snoop_wb_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int BEATS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_CH-1:0]           snoop,
    input  logic [N_CH-1:0]           hit_modified,
    input  logic                      rd,
    input  logic                      wr,
    input  logic                      wb_ack,
    input  logic                      fetch_ack,
    output logic                      writeback,
    output logic [ch_w(N_CH)-1:0]     wb_ch,
    output logic [beat_w(BEATS)-1:0]  wb_beat,
    output logic                      wb_last,
    output logic                      fetch,
    output logic                      busy,
    output logic                      overrun
);

    localparam int CH_W   = ch_w(N_CH);
    localparam int BEAT_W = beat_w(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH - 1);

    state_e            state_q, state_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic              fetch_pend_q, fetch_pend_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   wb_ch_q, wb_ch_d;
    logic [N_CH-1:0]   wb_oh_q, wb_oh_d;
    logic [BEAT_W-1:0] wb_beat_q, wb_beat_d;
    logic              writeback_q, writeback_d;
    logic              wb_last_q, wb_last_d;
    logic              fetch_q, fetch_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic [N_CH-1:0]   hit, clr, pend_rem, arb_req, arb_gnt;
    logic [CH_W-1:0]   ptr_nxt, arb_ptr, arb_idx;
    logic              arb_any, final_ack, fetch_done;

    assign hit        = snoop & hit_modified;
    assign final_ack  = (state_q == WB) && wb_ack && (wb_beat_q == LAST_BEAT);
    assign fetch_done = (state_q == FETCH) && fetch_ack;
    assign clr        = final_ack ? wb_oh_q : '0;
    assign pend_d     = (pend_q & ~clr) | hit;
    // A hit on the channel finishing this cycle keeps it queued for the next pick
    assign pend_rem   = pend_q & ~(clr & ~hit);
    assign fetch_pend_d = fetch_done ? 1'b0 : (fetch_pend_q | rd | wr);
    assign ptr_nxt    = (wb_ch_q == LAST_CH) ? '0 : wb_ch_q + 1'b1;
    assign arb_req    = (state_q == WB) ? pend_rem : pend_q;
    assign arb_ptr    = (state_q == WB) ? ptr_nxt  : ptr_q;

    snoop_wb_rr_arb #(
        .N_CH (N_CH)
    ) u_arb (
        .req_i   (arb_req),
        .ptr_i   (arb_ptr),
        .grant_o (arb_gnt),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        state_d   = state_q;
        wb_ch_d   = wb_ch_q;
        wb_oh_d   = wb_oh_q;
        wb_beat_d = wb_beat_q;
        ptr_d     = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d   = WB;
                    wb_ch_d   = arb_idx;
                    wb_oh_d   = arb_gnt;
                    wb_beat_d = '0;
                end else if (fetch_pend_q) begin
                    state_d = FETCH;
                end
            end
            WB: begin
                if (wb_ack) begin
                    if (wb_beat_q == LAST_BEAT) begin
                        ptr_d     = ptr_nxt;
                        wb_beat_d = '0;
                        if (arb_any) begin
                            wb_ch_d = arb_idx;
                            wb_oh_d = arb_gnt;
                        end else if (fetch_pend_q) begin
                            state_d = FETCH;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        wb_beat_d = wb_beat_q + 1'b1;
                    end
                end
            end
            FETCH: begin
                if (fetch_ack) begin
                    if (arb_any) begin
                        state_d   = WB;
                        wb_ch_d   = arb_idx;
                        wb_oh_d   = arb_gnt;
                        wb_beat_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        writeback_d = (state_d == WB);
        wb_last_d   = (state_d == WB) && (wb_beat_d == LAST_BEAT);
        fetch_d     = (state_d == FETCH);
        busy_d      = (state_d != IDLE) || (|pend_d) || fetch_pend_d;
        overrun_d   = |(hit & pend_q & ~clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            fetch_pend_q <= 1'b0;
            ptr_q        <= '0;
            wb_ch_q      <= '0;
            wb_oh_q      <= '0;
            wb_beat_q    <= '0;
            writeback_q  <= 1'b0;
            wb_last_q    <= 1'b0;
            fetch_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            fetch_pend_q <= fetch_pend_d;
            ptr_q        <= ptr_d;
            wb_ch_q      <= wb_ch_d;
            wb_oh_q      <= wb_oh_d;
            wb_beat_q    <= wb_beat_d;
            writeback_q  <= writeback_d;
            wb_last_q    <= wb_last_d;
            fetch_q      <= fetch_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign writeback = writeback_q;
    assign wb_ch     = wb_ch_q;
    assign wb_beat   = wb_beat_q;
    assign wb_last   = wb_last_q;
    assign fetch     = fetch_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

`ifdef SNOOP_WB_ASSERT_EN
    localparam int SERVICE_BOUND = N_CH * (BEATS + 1) + 1;

    logic        ack_stall_q;
    logic [15:0] age_q [N_CH];

    // Service bound only holds while both acks have stayed high since reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_stall_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            if (!wb_ack || !fetch_ack) begin
                ack_stall_q <= 1'b1;
            end
            for (int i = 0; i < N_CH; i++) begin
                age_q[i] <= (pend_q[i] && !clr[i]) ? age_q[i] + 1'b1 : '0;
            end
        end
    end

    a_mutex: assert property (@(posedge clk) disable iff (!reset_n)
        !(writeback_q && fetch_q));
    a_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (writeback_q && !wb_ack) |=> (writeback_q && $stable(wb_ch_q) && $stable(wb_beat_q)));
    a_last: assert property (@(posedge clk) disable iff (!reset_n)
        wb_last_q == (writeback_q && (wb_beat_q == LAST_BEAT)));

    for (genvar g = 0; g < N_CH; g++) begin : g_service
        a_service: assert property (@(posedge clk) disable iff (!reset_n)
            !ack_stall_q |-> (age_q[g] <= 16'(SERVICE_BOUND)));
    end

    c_overrun: cover property (@(posedge clk) disable iff (!reset_n) overrun_q);
    c_requeue: cover property (@(posedge clk) disable iff (!reset_n) |(clr & hit));
`else
    // Checkers are compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_snoop_wb_ctrl.sv
module tb_snoop_wb_ctrl;

    localparam int N_CH  = 4;
    localparam int BEATS = 4;
    localparam int CW    = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N_CH-1:0] snoop, hit_modified;
    logic            rd, wr, wb_ack, fetch_ack;
    logic            writeback;
    logic [1:0]      wb_ch;
    logic [1:0]      wb_beat;
    logic            wb_last, fetch, busy, overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snoop_wb_ctrl #(.N_CH(N_CH), .BEATS(BEATS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .snoop        (snoop),
        .hit_modified (hit_modified),
        .rd           (rd),
        .wr           (wr),
        .wb_ack       (wb_ack),
        .fetch_ack    (fetch_ack),
        .writeback    (writeback),
        .wb_ch        (wb_ch),
        .wb_beat      (wb_beat),
        .wb_last      (wb_last),
        .fetch        (fetch),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Reference model: activity 0 = none, 1 = writeback burst, 2 = line fetch
    int            m_mode, m_ch, m_beat, m_ptr;
    bit [N_CH-1:0] m_pend;
    bit            m_fp, m_ovr;

    // Observation bookkeeping
    int   cyc, wb_cycles, fetch_cycles, ovr_cycles, first_wb, last_wb;
    int   starts[$];
    logic prev_wb;
    logic [1:0] prev_beat;

    function automatic int rr_pick(bit [N_CH-1:0] req, int ptr);
        int j;
        for (int k = 0; k < N_CH; k++) begin
            j = (ptr + k) % N_CH;
            if (req[j[CW-1:0]]) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ch = 0; m_beat = 0; m_ptr = 0;
        m_pend = '0; m_fp = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_step();
        bit [N_CH-1:0] hits, nxt, rem;
        int  done;
        bit  fdone;
        hits  = snoop & hit_modified;
        done  = (m_mode == 1 && wb_ack && m_beat == BEATS - 1) ? m_ch : -1;
        fdone = (m_mode == 2) && fetch_ack;
        nxt   = m_pend;
        if (done >= 0) nxt[done[CW-1:0]] = 1'b0;
        m_ovr = |(hits & nxt);
        nxt   = nxt | hits;
        rem   = m_pend & nxt;
        case (m_mode)
            0: begin
                if (m_pend != 0) begin
                    m_mode = 1; m_ch = rr_pick(m_pend, m_ptr); m_beat = 0;
                end else if (m_fp) begin
                    m_mode = 2;
                end
            end
            1: begin
                if (wb_ack) begin
                    if (m_beat == BEATS - 1) begin
                        m_ptr  = (m_ch + 1) % N_CH;
                        m_beat = 0;
                        if (rem != 0) m_ch = rr_pick(rem, m_ptr);
                        else if (m_fp) m_mode = 2;
                        else m_mode = 0;
                    end else begin
                        m_beat++;
                    end
                end
            end
            default: begin
                if (fetch_ack) begin
                    if (m_pend != 0) begin
                        m_mode = 1; m_ch = rr_pick(m_pend, m_ptr); m_beat = 0;
                    end else begin
                        m_mode = 0;
                    end
                end
            end
        endcase
        if (fdone) m_fp = 1'b0;
        else m_fp = m_fp | rd | wr;
        m_pend = nxt;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("writeback", {31'd0, writeback}, (m_mode == 1) ? 1 : 0);
        chk("wb_ch",     {30'd0, wb_ch},     m_ch);
        chk("wb_beat",   {30'd0, wb_beat},   (m_mode == 1) ? m_beat : 0);
        chk("wb_last",   {31'd0, wb_last},   (m_mode == 1 && m_beat == BEATS - 1) ? 1 : 0);
        chk("fetch",     {31'd0, fetch},     (m_mode == 2) ? 1 : 0);
        chk("busy",      {31'd0, busy},      (m_mode != 0 || m_pend != 0 || m_fp) ? 1 : 0);
        chk("overrun",   {31'd0, overrun},   m_ovr ? 1 : 0);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_writeback"}, {31'd0, writeback}, 0);
        chk({tag, "_wb_ch"},     {30'd0, wb_ch},     0);
        chk({tag, "_wb_beat"},   {30'd0, wb_beat},   0);
        chk({tag, "_wb_last"},   {31'd0, wb_last},   0);
        chk({tag, "_fetch"},     {31'd0, fetch},     0);
        chk({tag, "_busy"},      {31'd0, busy},      0);
        chk({tag, "_overrun"},   {31'd0, overrun},   0);
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        cyc++;
        check_model();
        if (writeback === 1'b1) begin
            if (wb_beat == 0 && !(prev_wb && prev_beat == 0)) starts.push_back(int'(wb_ch));
            wb_cycles++;
            if (first_wb < 0) first_wb = cyc;
            last_wb = cyc;
        end
        if (fetch === 1'b1) fetch_cycles++;
        if (overrun === 1'b1) ovr_cycles++;
        prev_wb   = writeback;
        prev_beat = wb_beat;
    endtask

    task automatic clr_stats();
        starts.delete();
        wb_cycles = 0; fetch_cycles = 0; ovr_cycles = 0;
        first_wb = -1; last_wb = -1;
    endtask

    task automatic hit(logic [N_CH-1:0] mask);
        snoop = mask; hit_modified = mask;
        step();
        snoop = '0; hit_modified = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Burst start order packed as count<<28 | ch0 | ch1<<4 | ch2<<8
    function automatic logic [31:0] enc_starts();
        logic [31:0] v;
        v = 32'(starts.size()) << 28;
        for (int i = 0; i < 3 && i < starts.size(); i++) v |= 32'(starts[i]) << (4 * i);
        return v;
    endfunction

    function automatic logic [31:0] seq(int n, int a, int b, int c);
        return (32'(n) << 28) | 32'(a) | (32'(b) << 4) | (32'(c) << 8);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; snoop = '0; hit_modified = '0;
        rd = 1'b0; wr = 1'b0; wb_ack = 1'b0; fetch_ack = 1'b0;
        prev_wb = 1'b0; prev_beat = '0; cyc = 0;
        model_reset();
        clr_stats();
        step();
        chk_all_zero("reset");
        step();
        reset_n = 1'b1;

        // Single ch2 burst, acks always high
        wb_ack = 1'b1;
        clr_stats();
        hit(4'b0100);
        step();
        chk("lat_writeback", {31'd0, writeback}, 1);
        chk("lat_wb_ch", {30'd0, wb_ch}, 2);
        for (int n = 0; n < 5; n++) step();
        chk("single_wb_cycles", wb_cycles, 4);
        chk("single_idle_busy", {31'd0, busy}, 0);
        chk("single_order", enc_starts(), seq(1, 2, 0, 0));

        // Three simultaneous hits from pointer 0, then 0 and 3
        do_reset();
        clr_stats();
        hit(4'b1011);
        for (int n = 0; n < 14; n++) step();
        chk("rr_order_013", enc_starts(), seq(3, 0, 1, 3));
        chk("rr_wb_cycles", wb_cycles, 12);
        chk("rr_no_gap", last_wb - first_wb + 1, 12);
        clr_stats();
        hit(4'b1001);
        for (int n = 0; n < 10; n++) step();
        chk("rr_order_03", enc_starts(), seq(2, 0, 3, 0));

        // rd during a ch1 burst waits for the final beat
        clr_stats();
        fetch_ack = 1'b0;
        hit(4'b0010);
        step();
        rd = 1'b1;
        step();
        rd = 1'b0;
        for (int n = 0; n < 20 && fetch !== 1'b1; n++) step();
        chk("fetch_rise", {31'd0, fetch}, 1);
        chk("fetch_after_wb", enc_starts(), seq(1, 1, 0, 0));
        chk("fetch_wb_done", wb_cycles, 4);
        for (int n = 0; n < 4; n++) step();
        chk("fetch_hold", {31'd0, fetch}, 1);
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        chk("fetch_drop", {31'd0, fetch}, 0);
        chk("fetch_len", fetch_cycles, 5);
        chk("fetch_idle_busy", {31'd0, busy}, 0);

        // Overrun while ch2 is stalled, then re-queue on the final beat
        do_reset();
        clr_stats();
        wb_ack = 1'b0;
        hit(4'b0100);
        step();
        hit(4'b0100);
        chk("overrun_pulse", {31'd0, overrun}, 1);
        step();
        chk("overrun_clear", {31'd0, overrun}, 0);
        wb_ack = 1'b1;
        for (int n = 0; n < 8; n++) step();
        chk("overrun_one_burst", enc_starts(), seq(1, 2, 0, 0));
        chk("overrun_count", ovr_cycles, 1);
        clr_stats();
        hit(4'b0100);
        for (int n = 0; n < 12 && !(writeback === 1'b1 && wb_beat == 2'd3); n++) step();
        chk("requeue_last_beat", {31'd0, wb_last}, 1);
        hit(4'b0100);
        for (int n = 0; n < 8; n++) step();
        chk("requeue_order", enc_starts(), seq(2, 2, 2, 0));
        chk("requeue_no_overrun", ovr_cycles, 0);

        // Asynchronous reset during beat 1 of a ch3 burst
        do_reset();
        clr_stats();
        hit(4'b1000);
        for (int n = 0; n < 8 && !(writeback === 1'b1 && wb_beat == 2'd1); n++) step();
        chk("pre_reset_beat1", {30'd0, wb_beat}, 1);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_all_zero("midburst_reset");
        step();
        reset_n = 1'b1;
        clr_stats();
        for (int n = 0; n < 10; n++) step();
        chk("post_reset_quiet", wb_cycles, 0);

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < N_CH; b++) begin
                snoop[b]        = ($urandom_range(0, 5) == 0);
                hit_modified[b] = ($urandom_range(0, 1) == 1);
            end
            rd        = ($urandom_range(0, 15) == 0);
            wr        = ($urandom_range(0, 15) == 0);
            wb_ack    = ($urandom_range(0, 3) != 0);
            fetch_ack = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
